pi_stream_fifo: RTL and testbench
=================================

Name: pi_stream_fifo

Overview:
- Parametrised successor to the Pi serial input block.
- Deserialises the Raspberry Pi bit stream into CHANNELS-word frames and buffers them in a DEPTH-frame FIFO.
- Hands one frame to the I2S output stage per `ready` request.
- Raises `rpi_interrupt` with hysteresis so the Pi refills before the buffer starves.
- Everything runs on `clk`; Pi-side inputs are synchronised inside the block.

Parameters:
- WIDTH, 16: bits per sample word (2..32).
- CHANNELS, 2: words per frame (1..8).
- DEPTH, 32: FIFO depth in frames; power of two, >= 4.
- MSB_FIRST, 1: 1 = first serial bit is word bit WIDTH-1; 0 = first bit is bit 0.
- LOW_WATER, 8: interrupt asserts when level <= LOW_WATER.
- HIGH_WATER, 24: interrupt deasserts when level >= HIGH_WATER; must be > LOW_WATER and <= DEPTH.

Ports:
- clk, input, 1: main clock.
- rst_n, input, 1: asynchronous active-low reset.
- rpi_clk, input, 1: Pi shift clock, asynchronous to clk.
- serial, input, 1: Pi serial data.
- rpi_cs_n, input, 1: Pi frame select, active low; high = idle/resync.
- ready, input, 1: output stage requests next frame, rising edge, asynchronous.
- clr_flags, input, 1: synchronous clear of sticky flags.
- rpi_interrupt, output, 1: Pi must send more data.
- data, output, CHANNELS*WIDTH: current frame; channel 0 in bits [WIDTH-1:0].
- data_valid, output, 1: one-clk pulse when data updates from the FIFO.
- level, output, $clog2(DEPTH)+1: frames stored.
- overflow, output, 1: sticky; a completed frame was dropped.
- underflow, output, 1: sticky; ready arrived while empty.

Behaviour:
- Reset (async assert, sync release): all outputs 0; pointers, bit counter and channel counter 0; all synchronisers 0.
- Sync: rpi_clk, serial, rpi_cs_n and ready each pass through 2 flops plus an edge register.
  - A pin edge is acted on in the 3rd clk after it changes.
  - Pi clock high and low phases must each be >= 3 clk periods. Serial must be stable for 2 clk before and after the rpi_clk rise.
- Shift: on a synced rpi_clk rising edge with synced rpi_cs_n low, the synced serial bit goes into word bit position bit_cnt (MSB_FIRST=1: WIDTH-1-bit_cnt), and bit_cnt increments.
  - When bit_cnt reaches WIDTH-1 on that edge, the word is stored into frame slot ch_cnt, bit_cnt becomes 0, and ch_cnt increments.
  - When the last channel completes, ch_cnt becomes 0 and a push is requested in the same cycle.
- Resync: while synced rpi_cs_n is high, bit_cnt and ch_cnt are held at 0. A partial frame is discarded silently; no flag.
- Push: accepted if level < DEPTH, or if a pop happens in the same cycle. Otherwise the frame is dropped and overflow is set. wr_ptr wraps modulo DEPTH.
- Pop: on a synced ready rising edge:
  - level > 0: data <= FIFO[rd_ptr] on the next clk edge, data_valid pulses that cycle, rd_ptr increments and wraps.
  - level = 0: data <= 0 (mute), data_valid pulses, underflow is set.
- Simultaneous push and pop: both happen; level unchanged. Push into an empty FIFO in the same cycle as a pop still yields the mute/underflow response; the new frame stays queued.
- Level: +1 on push only, -1 on pop only. Never exceeds DEPTH, never below 0.
- Interrupt: a registered flag.
  - Set when next level <= LOW_WATER; cleared when next level >= HIGH_WATER; otherwise held.
  - After reset it is 0 for one cycle, then 1 (level 0 <= LOW_WATER).
- Flags: clr_flags clears overflow and underflow. A same-cycle set wins over clear.
- Reset mid-word or mid-frame: all partial data is lost; FIFO is empty after release.

Test Plan (WIDTH=16, CHANNELS=2, DEPTH=8, LOW_WATER=2, HIGH_WATER=6, MSB_FIRST=1, rpi_clk period 8 clk):
- Reset, then idle 4 clk -> data=0, level=0, rpi_interrupt 0 in cycle 1 and 1 from cycle 2; no flags.
- Shift 0x1234 then 0xABCD with cs_n low, then pulse ready -> level 1 then 0; data=0xABCD1234; one data_valid pulse 4 clk after the ready pin rise.
- Push 6 frames -> rpi_interrupt falls when level hits 6. Pop until level 2 -> rpi_interrupt rises at level 2, not at 5..3.
- Push 9 frames with no ready -> level=8, overflow=1, 9th frame absent. Pop 8 frames -> frames 1..8 in order. clr_flags -> overflow=0.
- Ready with empty FIFO -> data=0, data_valid pulse, underflow=1. Same test with MSB_FIRST=0 -> serial 0x1234 LSB-first reads back 0x1234.
- Shift 7 bits, raise cs_n for 4 rpi_clk, lower it, shift a full frame -> only the full frame is stored, bits correct. Assert rst_n low mid-word -> level=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/pi_stream_fifo.sv
// Raspberry Pi serial input: synchronises the Pi pins, deserialises words into
// CHANNELS-word frames, buffers frames in a DEPTH-entry FIFO and hands one frame
// per ready request to the output stage. rpi_interrupt asks the Pi for more data
// with low/high watermark hysteresis.
module pi_stream_fifo #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned LOW_WATER  = 8,
    parameter int unsigned HIGH_WATER = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rpi_clk,
    input  logic                         serial,
    input  logic                         rpi_cs_n,
    input  logic                         ready,
    input  logic                         clr_flags,
    output logic                         rpi_interrupt,
    output logic [CHANNELS*WIDTH-1:0]    data,
    output logic                         data_valid,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned FW = CHANNELS * WIDTH;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_L   = LW'(LOW_WATER);
    localparam logic [LW-1:0] HIGH_L  = LW'(HIGH_WATER);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);

    // Pin order in the synchroniser vectors: {ready, rpi_cs_n, serial, rpi_clk}
    logic [3:0] sync1_q, sync2_q, sync3_q;

    logic rpi_rise, ser_bit, cs_n_s, pop_req;

    // Deserialiser state
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] ch_cnt_q, ch_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [BW-1:0] bit_pos;
    logic push_req;

    // FIFO state
    logic [FW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic push_ok, pop_ok;
    logic irq_q, irq_d;
    logic [FW-1:0] data_q;
    logic data_valid_q;
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    // Two-flop synchronisers plus an edge/history stage for every Pi-side pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= {ready, rpi_cs_n, serial, rpi_clk};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Serial data and select use the third stage so they line up with the
    // clock edge detected between stages two and three.
    assign rpi_rise = sync2_q[0] & ~sync3_q[0];
    assign ser_bit  = sync3_q[1];
    assign cs_n_s   = sync3_q[2];
    assign pop_req  = sync2_q[3] & ~sync3_q[3];

    // Bit/channel counting, word assembly and frame completion
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        word_d    = word_q;
        frame_d   = frame_q;
        push_req  = 1'b0;
        bit_pos   = (MSB_FIRST != 0) ? (LAST_BIT - bit_cnt_q) : bit_cnt_q;
        if (cs_n_s) begin
            // Deselect resynchronises: any partial frame is abandoned
            bit_cnt_d = '0;
            ch_cnt_d  = '0;
        end else if (rpi_rise) begin
            word_d[bit_pos] = ser_bit;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_cnt_q == CW'(c)) begin
                        frame_d[c*WIDTH +: WIDTH] = word_d;
                    end
                end
                if (ch_cnt_q == LAST_CH) begin
                    ch_cnt_d = '0;
                    push_req = 1'b1;
                end else begin
                    ch_cnt_d = ch_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Deserialiser registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            ch_cnt_q  <= '0;
            word_q    <= '0;
            frame_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            word_q    <= word_d;
            frame_q   <= frame_d;
        end
    end

    // Push/pop arbitration, level, watermark hysteresis and sticky flags.
    // A pop on an empty FIFO mutes even if a frame is pushed that same cycle.
    always_comb begin
        pop_ok  = pop_req && (level_q != '0);
        push_ok = push_req && ((level_q != DEPTH_L) || pop_req);
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
        irq_d = irq_q;
        if (level_d <= LOW_L) begin
            irq_d = 1'b1;
        end else if (level_d >= HIGH_L) begin
            irq_d = 1'b0;
        end
        overflow_d  = (push_req && !push_ok) || (overflow_q && !clr_flags);
        underflow_d = (pop_req && !pop_ok) || (underflow_q && !clr_flags);
    end

    // Frame storage; no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= frame_d;
        end
    end

    // FIFO pointers, output frame and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            irq_q        <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop_req) begin
                data_q <= pop_ok ? mem_q[rd_ptr_q] : '0;
            end
            data_valid_q <= pop_req;
            level_q      <= level_d;
            irq_q        <= irq_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rpi_interrupt = irq_q;
    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_pi_stream_fifo.sv
// Bench for pi_stream_fifo: an MSB-first and an LSB-first instance share all
// inputs; a frame-queue model tracks expected level, data, interrupt and flags.
module tb_pi_stream_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rpi_clk = 1'b0;
    logic serial = 1'b0;
    logic rpi_cs_n = 1'b1;
    logic ready = 1'b0;
    logic clr_flags = 1'b0;

    logic        irq_m, irq_l;
    logic [31:0] data_m, data_l;
    logic        dv_m, dv_l;
    logic [3:0]  level_m, level_l;
    logic        ovf_m, ovf_l, udf_m, udf_l;

    pi_stream_fifo #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(8), .MSB_FIRST(1), .LOW_WATER(2), .HIGH_WATER(6)
    ) dut_msb (
        .clk(clk), .rst_n(rst_n), .rpi_clk(rpi_clk), .serial(serial), .rpi_cs_n(rpi_cs_n),
        .ready(ready), .clr_flags(clr_flags), .rpi_interrupt(irq_m), .data(data_m),
        .data_valid(dv_m), .level(level_m), .overflow(ovf_m), .underflow(udf_m)
    );

    pi_stream_fifo #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(8), .MSB_FIRST(0), .LOW_WATER(2), .HIGH_WATER(6)
    ) dut_lsb (
        .clk(clk), .rst_n(rst_n), .rpi_clk(rpi_clk), .serial(serial), .rpi_cs_n(rpi_cs_n),
        .ready(ready), .clr_flags(clr_flags), .rpi_interrupt(irq_l), .data(data_l),
        .data_valid(dv_l), .level(level_l), .overflow(ovf_l), .underflow(udf_l)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: queue of frames as sent in MSB-first terms
    logic [31:0] mq[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    logic m_irq = 1'b0;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] exp_msb;
        logic [31:0] exp_lsb;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    function automatic logic [31:0] lsb_view(input logic [31:0] f);
        return {rev16(f[31:16]), rev16(f[15:0])};
    endfunction

    task automatic model_irq();
        if (mq.size() <= 2) m_irq = 1'b1;
        else if (mq.size() >= 6) m_irq = 1'b0;
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One Pi clock: serial changes at the fall, rise sampled 4 clk later
    task automatic send_bit(input logic b);
        serial = b;
        rpi_clk = 1'b0;
        clk_n(4);
        rpi_clk = 1'b1;
        clk_n(4);
    endtask

    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 15; i >= 0; i--) send_bit(w0[i]);
        for (int i = 15; i >= 0; i--) send_bit(w1[i]);
        if (mq.size() < 8) mq.push_back({w1, w0});
        else m_ovf = 1'b1;
        model_irq();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 64'(level_m), 64'(mq.size()));
        chk({tag, ".level_lsb"}, 64'(level_l), 64'(mq.size()));
        chk({tag, ".irq"}, 64'(irq_m), 64'(m_irq));
        chk({tag, ".ovf"}, 64'(ovf_m), 64'(m_ovf));
        chk({tag, ".udf"}, 64'(udf_m), 64'(m_udf));
    endtask

    task automatic pop_frame(input string tag);
        logic [31:0] exp;
        logic [31:0] got_m, got_l;
        int hits_m, hits_l, at_k;
        got_m = 'x;
        got_l = 'x;
        hits_m = 0;
        hits_l = 0;
        at_k = 0;
        if (mq.size() > 0) begin
            exp = mq.pop_front();
        end else begin
            exp = '0;
            m_udf = 1'b1;
        end
        model_irq();
        ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dv_m === 1'b1) begin
                hits_m++;
                at_k = k;
                got_m = data_m;
            end
            if (dv_l === 1'b1) begin
                hits_l++;
                got_l = data_l;
            end
        end
        ready = 1'b0;
        clk_n(4);
        chk({tag, ".dv_pulses"}, 64'(hits_m), 64'd1);
        chk({tag, ".dv_pulses_lsb"}, 64'(hits_l), 64'd1);
        chk({tag, ".dv_latency_ok"}, 64'(at_k == 3 || at_k == 4), 64'd1);
        chk({tag, ".data"}, 64'(got_m), 64'(exp));
        chk({tag, ".data_lsb"}, 64'(got_l), 64'(lsb_view(exp)));
        check_state(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".z_level"}, 64'(level_m), 64'd0);
        chk({tag, ".z_data"}, 64'(data_m), 64'd0);
        chk({tag, ".z_data_lsb"}, 64'(data_l), 64'd0);
        chk({tag, ".z_dv"}, 64'(dv_m), 64'd0);
        chk({tag, ".z_irq"}, 64'(irq_m), 64'd0);
        chk({tag, ".z_ovf"}, 64'(ovf_m), 64'd0);
        chk({tag, ".z_udf"}, 64'(udf_m), 64'd0);
    endtask

    // Release reset with the Pi deselected so stale pin levels cannot shift bits
    task automatic release_reset(input string tag);
        rpi_cs_n = 1'b1;
        ready = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rst_n = 1'b1;
        #1;
        chk({tag, ".irq_first_cycle"}, 64'(irq_m), 64'd0);
        @(negedge clk);
        m_irq = 1'b1;
        chk({tag, ".irq_second_cycle"}, 64'(irq_m), 64'd1);
        clk_n(4);
        check_state({tag, ".idle"});
        chk({tag, ".idle_data"}, 64'(data_m), 64'd0);
        rpi_cs_n = 1'b0;
        clk_n(4);
    endtask

    initial begin
        vecs[0] = '{w0: 16'h1234, w1: 16'hABCD, exp_msb: 32'hABCD1234, exp_lsb: 32'hB3D52C48};
        vecs[1] = '{w0: 16'h2C48, w1: 16'h0000, exp_msb: 32'h00002C48, exp_lsb: 32'h00001234};
        vecs[2] = '{w0: 16'hFFFF, w1: 16'h0001, exp_msb: 32'h0001FFFF, exp_lsb: 32'h8000FFFF};
        vecs[3] = '{w0: 16'h8000, w1: 16'h00F0, exp_msb: 32'h00F08000, exp_lsb: 32'h0F000001};

        // Power-on reset
        clk_n(2);
        check_all_zero("por");
        release_reset("por");

        // Table-driven single frames, both bit orders
        for (int i = 0; i < 4; i++) begin
            logic [31:0] gm, gl;
            int hits;
            send_frame(vecs[i].w0, vecs[i].w1);
            check_state($sformatf("vec%0d.pushed", i));
            void'(mq.pop_front());
            model_irq();
            hits = 0;
            gm = 'x;
            gl = 'x;
            ready = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (dv_m === 1'b1) begin
                    hits++;
                    gm = data_m;
                    gl = data_l;
                end
            end
            ready = 1'b0;
            clk_n(4);
            chk($sformatf("vec%0d.dv", i), 64'(hits), 64'd1);
            chk($sformatf("vec%0d.data_msb", i), 64'(gm), 64'(vecs[i].exp_msb));
            chk($sformatf("vec%0d.data_lsb", i), 64'(gl), 64'(vecs[i].exp_lsb));
            check_state($sformatf("vec%0d.popped", i));
        end

        // Interrupt hysteresis: falls at 6 on the way up, rises only at 2 going down
        for (int i = 0; i < 6; i++) begin
            send_frame(16'($urandom), 16'($urandom));
            check_state($sformatf("hyst_up%0d", i));
        end
        for (int i = 0; i < 6; i++) pop_frame($sformatf("hyst_dn%0d", i));

        // Overflow: 9 frames into 8 slots, then drain in order
        for (int i = 1; i <= 9; i++) begin
            send_frame(16'(i), 16'(16'hA500 + i));
            check_state($sformatf("ovf_push%0d", i));
        end
        for (int i = 1; i <= 8; i++) pop_frame($sformatf("ovf_pop%0d", i));
        clr_flags = 1'b1;
        clk_n(1);
        clr_flags = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        clk_n(1);
        check_state("clr_ovf");

        // Underflow: pop while empty mutes the output
        pop_frame("udf");
        clr_flags = 1'b1;
        clk_n(1);
        clr_flags = 1'b0;
        m_udf = 1'b0;
        clk_n(1);
        check_state("clr_udf");

        // Resync: 7 stray bits, deselect for 4 Pi clocks, then a clean frame
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        rpi_cs_n = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        rpi_cs_n = 1'b0;
        clk_n(4);
        check_state("resync_partial");
        send_frame(16'h5A5A, 16'hC3C3);
        check_state("resync_frame");
        pop_frame("resync_pop");

        // Randomised push/pop mix against the model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 2) begin
                send_frame(16'($urandom), 16'($urandom));
                check_state($sformatf("rnd%0d.push", i));
            end else begin
                pop_frame($sformatf("rnd%0d.pop", i));
            end
        end
        while (mq.size() > 0) pop_frame("rnd_drain");

        // Reset mid-word with a non-empty FIFO and non-zero output frame
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        pop_frame("pre_rst");
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        clk_n(3);
        release_reset("mid_rst");
        send_frame(16'h0F0F, 16'h7E81);
        check_state("post_rst_push");
        pop_frame("post_rst_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
